flex_counter_lead: RTL and testbench
====================================

# flex_counter_lead

Parametrised programmable-rollover counter with a programmable early-warning flag, a one-shot stop mode and a saturating wrap tally. It generalises the fixed "two-before-rollover" early-warning counter used by the USB TX/RX byte and bit timing logic. A single instance can be used for packet-length counting, where the early flag pre-fetches the next byte. It can also be used for bit-period timing, where one-shot mode stops at the terminal count and raises `done`.

## Interface
- `NUM_CNT_BITS`, default 4: width of `count_out`, `rollover_val`, `lead_val`.
- `WRAP_BITS`, default 8: width of `wrap_count`.
- `clk` in 1: rising-edge clock.
- `n_rst` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `clear` in 1: synchronous restart of the count sequence.
- `count_enable` in 1: advance count this cycle.
- `one_shot` in 1: stop at terminal count instead of wrapping; sampled on enabled cycles.
- `rollover_val` in `NUM_CNT_BITS`: terminal count. The sequence is 1..`rollover_val`.
- `lead_val` in `NUM_CNT_BITS`: early-flag distance before the terminal count.
- `count_out` out `NUM_CNT_BITS`: current count, registered.
- `rollover_flag` out 1: high while `count_out == rollover_val`.
- `lead_flag` out 1: high while `count_out == rollover_val - lead_val`.
- `done` out 1: one-shot terminal reached; held until `clear` or reset.
- `wrap_count` out `WRAP_BITS`: number of wraps since `clear`, saturating.

## Operation
- Priority is `n_rst` low, then `clear`, then `count_enable`, then hold.
- Reset values and `clear` values are identical:
  - `count_out` = 1.
  - `rollover_flag`, `lead_flag`, `done` = 0.
  - `wrap_count` = 0.
  - state = CNT_RUN.
- FSM states are CNT_RUN and CNT_DONE.
- In CNT_RUN, an enabled cycle computes `nxt`:
  - If `count_out >= rollover_val`: `nxt` = 1 (wrap). `wrap_count` increments, saturating at all-ones. The exceptions below apply first.
  - Exception: `count_out == rollover_val` and `one_shot` = 1. Then `nxt` = `count_out`, there is no wrap increment, and the next state is CNT_DONE with `done` = 1.
  - Otherwise `nxt` = `count_out + 1`.
- Flags are updated on enabled cycles only, and are registered from `nxt`:
  - `rollover_flag` <= (`nxt == rollover_val`).
  - `lead_flag` <= (`lead_val != 0`) && (`lead_val < rollover_val`) && (`nxt == rollover_val - lead_val`).
- In CNT_DONE, `count_enable` is ignored and all outputs hold. Only `clear` or reset leaves CNT_DONE.
- `rollover_val` = 0 disables counting:
  - Enabled cycles force `count_out` = 1 and both flags to 0.
  - No wrap is counted and `done` is never set.
- `rollover_val` = 1:
  - `count_out` stays at 1.
  - Every enabled cycle counts as a wrap unless `one_shot` is set.
  - `rollover_flag` = 1 after the first enabled cycle.
- `rollover_val` lowered below `count_out` mid-sequence: the next enabled cycle wraps to 1, and the wrap is counted.
- `lead_val` changes take effect on the next enabled cycle. Flags are never re-evaluated on disabled cycles.
- All subtraction is done at `NUM_CNT_BITS` + 1 bits. No compare may alias through underflow.

## Timing
- All outputs are registered and change only on a `clk` rising edge.
- `clear` and `n_rst` take effect on the edge where they are sampled. The outputs show reset values in the following cycle.
- Latency from `count_enable` high to the `count_out` update is 1 cycle.
- `rollover_flag` and `lead_flag` are coincident with the `count_out` value they describe. They are never one cycle late.
- `rollover_flag` lasts exactly as long as `count_out` sits at terminal, which may span several disabled cycles.
- The `wrap_count` increment is visible in the same cycle that `count_out` returns to 1.
- `done` rises in the cycle after the enabled cycle taken at terminal with `one_shot` = 1.

## Structure
- Package `flex_counter_pkg` holds:
  - `typedef enum logic {CNT_RUN, CNT_DONE} cnt_state_t`.
  - The localparam for the reset/clear count value (1).
- Sub-module `flex_wrap_tally` (parameter `WRAP_BITS`): a saturating incrementer with sync clear, used for `wrap_count`.
- Top level: one state register, one count register, flag registers, and a single combinational next-state block.

## Test plan
- Reset, then `rollover_val`=5, `lead_val`=2, enable continuously:
  - `count_out` runs 1,2,3,4,5,1,2.
  - `lead_flag` is high only at count 3.
  - `rollover_flag` is high only at count 5.
  - `wrap_count` is 1 after the first wrap.
- `one_shot`=1, `rollover_val`=3, continuous enable:
  - Count 1,2,3, then holds at 3.
  - `done`=1 one cycle after the first enabled cycle at 3.
  - `wrap_count`=0.
  - Asserting `clear` returns to 1 with `done`=0.
- `rollover_val`=4, toggle `count_enable` every other cycle: count and flags hold on disabled cycles, and `rollover_flag` stays high for both cycles at 4.
- Edge values:
  - `lead_val`=0 or `lead_val`=6 with `rollover_val`=6: `lead_flag` never asserts.
  - `rollover_val`=0: `count_out` stays 1 and the flags stay 0.
- `WRAP_BITS`=2, `rollover_val`=1, enable for 10 cycles: `wrap_count` saturates at 3.
- At count 7 of `rollover_val`=9, drive `n_rst`=0 for one cycle: all outputs return to their reset values on the next edge, even if `count_enable` is also high.

Source files
------------

// File: rtl/flex_counter_pkg.sv
// rtl/flex_counter_pkg.sv - shared types and constants for the flex counter
package flex_counter_pkg;
  typedef enum logic {CNT_RUN, CNT_DONE} cnt_state_t;

  localparam int unsigned CNT_INIT = 1;
endpackage

// File: rtl/flex_wrap_tally.sv
// rtl/flex_wrap_tally.sv - saturating wrap tally with synchronous clear
module flex_wrap_tally #(
  parameter int WRAP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 inc,
  output logic [WRAP_BITS-1:0] count
);

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      count <= '0;
    end else if (inc && (count != {WRAP_BITS{1'b1}})) begin
      count <= count + WRAP_BITS'(1);
    end
  end

endmodule

// File: rtl/flex_counter_lead.sv
// rtl/flex_counter_lead.sv - programmable-rollover counter with lead flag, one-shot stop and wrap tally
module flex_counter_lead
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int WRAP_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    one_shot,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CNT_BITS-1:0] lead_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    lead_flag,
  output logic                    done,
  output logic [WRAP_BITS-1:0]    wrap_count
);

  localparam logic [NUM_CNT_BITS-1:0] INIT = NUM_CNT_BITS'(CNT_INIT);

  cnt_state_t              state, state_nxt;
  logic [NUM_CNT_BITS-1:0] nxt, cnt_nxt;
  logic                    rf_nxt, lf_nxt, done_nxt, wrap_inc;
  logic [NUM_CNT_BITS:0]   lead_target;

  // One extra bit so rollover_val - lead_val can never alias through underflow
  assign lead_target = {1'b0, rollover_val} - {1'b0, lead_val};

  always_comb begin
    state_nxt = state;
    nxt       = count_out;
    cnt_nxt   = count_out;
    rf_nxt    = rollover_flag;
    lf_nxt    = lead_flag;
    done_nxt  = done;
    wrap_inc  = 1'b0;
    if ((state == CNT_RUN) && count_enable) begin
      if (rollover_val == '0) begin
        nxt = INIT;
      end else if ((count_out == rollover_val) && one_shot) begin
        nxt       = count_out;
        state_nxt = CNT_DONE;
        done_nxt  = 1'b1;
      end else if (count_out >= rollover_val) begin
        nxt      = INIT;
        wrap_inc = 1'b1;
      end else begin
        nxt = count_out + NUM_CNT_BITS'(1);
      end
      cnt_nxt = nxt;
      rf_nxt  = (nxt == rollover_val);
      lf_nxt  = (lead_val != '0) && (lead_val < rollover_val) &&
                ({1'b0, nxt} == lead_target);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      state         <= CNT_RUN;
      count_out     <= INIT;
      rollover_flag <= 1'b0;
      lead_flag     <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      count_out     <= cnt_nxt;
      rollover_flag <= rf_nxt;
      lead_flag     <= lf_nxt;
      done          <= done_nxt;
    end
  end

  flex_wrap_tally #(.WRAP_BITS(WRAP_BITS)) u_wrap_tally (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (wrap_inc),
    .count (wrap_count)
  );

endmodule

// File: tb/tb_flex_counter_lead.sv
// tb/tb_flex_counter_lead.sv - scoreboard bench for flex_counter_lead
module tb_flex_counter_lead;

  localparam int NB = 4;
  localparam int WB = 2;
  localparam int WRAP_MAX = (1 << WB) - 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          clear = 1'b0;
  logic          count_enable = 1'b0;
  logic          one_shot = 1'b0;
  logic [NB-1:0] rollover_val = '0;
  logic [NB-1:0] lead_val = '0;
  logic [NB-1:0] count_out;
  logic          rollover_flag, lead_flag, done;
  logic [WB-1:0] wrap_count;

  flex_counter_lead #(.NUM_CNT_BITS(NB), .WRAP_BITS(WB)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .count_enable  (count_enable),
    .one_shot      (one_shot),
    .rollover_val  (rollover_val),
    .lead_val      (lead_val),
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .lead_flag     (lead_flag),
    .done          (done),
    .wrap_count    (wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int rf;
    int lf;
    int dn;
    int wrap;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model: plain integers describing the count sequence
  int m_cnt = 1, m_rf = 0, m_lf = 0, m_dn = 0, m_wrap = 0;

  task automatic model_edge(input bit r, c, e, o, input int rv, lv);
    if (!r || c) begin
      m_cnt = 1; m_rf = 0; m_lf = 0; m_dn = 0; m_wrap = 0;
    end else if (e && !m_dn) begin
      if (rv == 0) begin
        m_cnt = 1;
      end else if (m_cnt == rv && o) begin
        m_dn = 1;
      end else if (m_cnt >= rv) begin
        m_cnt = 1;
        if (m_wrap < WRAP_MAX) m_wrap++;
      end else begin
        m_cnt++;
      end
      m_rf = (m_cnt == rv) ? 1 : 0;
      m_lf = (lv > 0 && lv < rv && m_cnt == rv - lv) ? 1 : 0;
    end
  endtask

  task automatic step(input bit r, c, e, o, input int rv, lv);
    exp_t x;
    @(negedge clk);
    n_rst = r; clear = c; count_enable = e; one_shot = o;
    rollover_val = NB'(rv); lead_val = NB'(lv);
    @(posedge clk);
    model_edge(r, c, e, o, rv, lv);
    x.cnt = m_cnt; x.rf = m_rf; x.lf = m_lf; x.dn = m_dn; x.wrap = m_wrap;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    total++;
    if (act !== 8'(exp)) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("count_out", 8'(count_out), e.cnt);
      chk("rollover_flag", 8'(rollover_flag), e.rf);
      chk("lead_flag", 8'(lead_flag), e.lf);
      chk("done", 8'(done), e.dn);
      chk("wrap_count", 8'(wrap_count), e.wrap);
    end
  end

  initial begin
    int rv, lv;
    bit os;
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // rollover 5 lead 2
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 5, 2);
    // one-shot at 3, then clear
    step(1, 1, 0, 0, 3, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 3, 0);
    step(1, 1, 1, 1, 3, 0);
    step(1, 0, 0, 0, 3, 0);
    // toggled enable at rollover 4
    for (int i = 0; i < 12; i++) step(1, 0, (i % 2) == 0, 0, 4, 1);
    // lead distance 0 and equal to rollover
    step(1, 1, 0, 0, 6, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 6, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 6, 6);
    // rollover 0 disables counting
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 3);
    // rollover 1: every enabled cycle wraps, tally saturates
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 1, 0);
    // reset mid-sequence with enable high
    step(1, 1, 0, 0, 9, 2);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 9, 2);
    step(0, 0, 1, 0, 9, 2);
    step(1, 0, 1, 0, 9, 2);
    // rollover lowered below the current count
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, 12, 3);
    step(1, 0, 1, 0, 4, 3);
    step(1, 0, 1, 0, 4, 3);
    // randomized traffic
    rv = 7; lv = 2; os = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(29) == 0) rv = $urandom_range(15);
      if ($urandom_range(9) == 0) lv = $urandom_range(15);
      if ($urandom_range(19) == 0) os = ~os;
      step($urandom_range(59) != 0, $urandom_range(24) == 0,
           $urandom_range(9) < 7, os, rv, lv);
    end
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
